onehot_index_encoder: RTL

- Sequential inverse of the team's 8-to-256 one-hot decoder.
- Accepts a 256-bit select vector over a valid/ready handshake.
- Emits the 8-bit index of every set bit, lowest first, one index per output handshake, and marks the final beat.
- Sits wherever a decoded one-hot or multi-hot select bus must be collapsed back to binary indices, e.g. a status-vector scanner or the decoder loop-back check.

---
 rtl/onehot_index_encoder_if.sv | 26 ++
 rtl/onehot_index_encoder.sv | 91 +++++++++
 2 files changed

// File: rtl/onehot_index_encoder_if.sv
// Handshake bundle for onehot_index_encoder: vector-in stream and index-out stream.
// slave = encoder side, master = producer/consumer side.
interface onehot_index_encoder_if #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned IDX_W = 8
);
  logic [WIDTH-1:0] in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             out_zero;
  logic             out_err;

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_idx, out_valid, out_last, out_zero, out_err
  );

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_idx, out_valid, out_last, out_zero, out_err
  );
endinterface

// File: rtl/onehot_index_encoder.sv
// Sequential one-hot/multi-hot to binary index encoder, lowest set bit first.
// Optional macro ONEHOT_ENC_STRICT_EN: one beat per vector, out_err flags popcount != 1.
module onehot_index_encoder #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  onehot_index_encoder_if.slave    bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] vec_q;
  logic             zero_q;
  logic [IDX_W-1:0] idx_c;
  logic             last_c;

  // Priority encoder over the held vector; descending scan leaves the lowest hit.
  always_comb begin
    idx_c = '0;
    for (int k = int'(WIDTH) - 1; k >= 0; k--) begin
      if (vec_q[k]) idx_c = IDX_W'(k);
    end
  end

`ifdef ONEHOT_ENC_STRICT_EN
  logic err_q;
  logic err_d;

  // Exactly one bit set is the only legal input in strict mode.
  assign err_d  = (bus.in_vec == '0) || ((bus.in_vec & (bus.in_vec - WIDTH'(1))) != '0);
  assign last_c = (state_q == EMIT);
`else
  logic [WIDTH-1:0] vec_d;

  // Removing the lowest set bit; anything left means more beats follow.
  assign vec_d  = vec_q & (vec_q - WIDTH'(1));
  assign last_c = (state_q == EMIT) && (vec_d == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      zero_q  <= 1'b0;
`ifdef ONEHOT_ENC_STRICT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            vec_q   <= bus.in_vec;
            zero_q  <= (bus.in_vec == '0);
`ifdef ONEHOT_ENC_STRICT_EN
            err_q   <= err_d;
`endif
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (last_c) begin
              vec_q   <= '0;
              state_q <= IDLE;
            end else begin
`ifndef ONEHOT_ENC_STRICT_EN
              vec_q   <= vec_d;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_idx   = idx_c;
  assign bus.out_last  = last_c;
  assign bus.out_zero  = (state_q == EMIT) && zero_q;
`ifdef ONEHOT_ENC_STRICT_EN
  assign bus.out_err   = (state_q == EMIT) && err_q;
`else
  assign bus.out_err   = 1'b0;
`endif

endmodule
